// File: rtl/sudoku_board_ctrl_pkg.sv
// sudoku_board_ctrl_pkg: board geometry, controller state encoding and the cell
// indexing shared with the VGA renderer.
package sudoku_board_ctrl_pkg;
    localparam int N           = 9;
    localparam int CELLS       = N * N;
    localparam int CELL_W      = 4;
    localparam int NUM_PUZZLES = 3;
    localparam int ROM_AW      = 9;
    localparam int IDX_W       = 7;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LOAD_LAST, S_CLEAR} state_t;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
        return IDX_W'(r) * IDX_W'(N) + IDX_W'(c);
    endfunction
endpackage

// File: rtl/sudoku_board_ctrl_arbiter.sv
// board_wr_arbiter: two-way round-robin between keypad and handwriting writes,
// with a requester masked out while its own ack is still high.
module board_wr_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_kp_req,
    input  logic i_hw_req,
    output logic o_grant,
    output logic o_grant_id,
    output logic o_kp_ack,
    output logic o_hw_ack
);
    logic r_last_hw, r_kp_ack, r_hw_ack;
    logic w_kp_ok, w_hw_ok;

    assign w_kp_ok    = i_en & i_kp_req & ~r_kp_ack;
    assign w_hw_ok    = i_en & i_hw_req & ~r_hw_ack;
    assign o_grant    = w_kp_ok | w_hw_ok;
    // on a tie the requester that was not served last wins
    assign o_grant_id = w_hw_ok & (~w_kp_ok | ~r_last_hw);
    assign o_kp_ack   = r_kp_ack;
    assign o_hw_ack   = r_hw_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_hw <= 1'b1;
            r_kp_ack  <= 1'b0;
            r_hw_ack  <= 1'b0;
        end else begin
            r_kp_ack <= o_grant & ~o_grant_id;
            r_hw_ack <= o_grant & o_grant_id;
            if (o_grant) r_last_hw <= o_grant_id;
        end
    end
endmodule

// File: rtl/sudoku_board_ctrl.sv
// sudoku_board_ctrl: owns the 9x9 board, loads puzzles from ROM, clears user
// entries, moves the cursor and applies arbitrated keypad/handwriting writes.
module sudoku_board_ctrl
    import sudoku_board_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_start,
    input  logic [1:0]              puzzle_sel,
    output logic                    rom_en,
    output logic [ROM_AW-1:0]       rom_addr,
    input  logic [CELL_W-1:0]       rom_data,
    input  logic                    clear_start,
    input  logic                    mv_up,
    input  logic                    mv_down,
    input  logic                    mv_left,
    input  logic                    mv_right,
    input  logic                    kp_req,
    input  logic [CELL_W-1:0]       kp_num,
    output logic                    kp_ack,
    input  logic                    hw_req,
    input  logic [CELL_W-1:0]       hw_num,
    output logic                    hw_ack,
    output logic                    wr_reject,
    output logic [CELLS*CELL_W-1:0] board,
    output logic [CELLS-1:0]        board_blank,
    output logic [3:0]              cursor_row,
    output logic [3:0]              cursor_col,
    output logic                    busy,
    output logic [6:0]              filled_cnt,
    output logic                    board_full
);
    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [CELLS*CELL_W-1:0] r_board;
    logic [CELLS-1:0]        r_blank;
    logic [3:0]              r_row, r_col;
    logic [6:0]              r_cnt;
    logic                    r_rom_en, r_wr_reject;
    logic [ROM_AW-1:0]       r_rom_addr;

    logic                    w_grant, w_gid, w_reject;
    logic                    w_ld_we, w_cl_we, w_wr_we, w_we;
    logic [IDX_W-1:0]        w_cur, w_widx;
    logic [CELL_W-1:0]       w_num, w_ld_val, w_wval, w_old;
    logic [ROM_AW-1:0]       w_base;
    logic [6:0]              w_cnt_nx;
    logic [3:0]              w_row_nx, w_col_nx;

    board_wr_arbiter u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (r_state == S_IDLE),
        .i_kp_req  (kp_req),
        .i_hw_req  (hw_req),
        .o_grant   (w_grant),
        .o_grant_id(w_gid),
        .o_kp_ack  (kp_ack),
        .o_hw_ack  (hw_ack)
    );

    assign w_base   = (puzzle_sel >= 2'(NUM_PUZZLES)) ? '0 : ROM_AW'(puzzle_sel) * ROM_AW'(CELLS);
    assign w_cur    = cell_idx(r_row, r_col);
    assign w_num    = w_gid ? hw_num : kp_num;
    assign w_reject = !r_blank[w_cur] || w_num > 4'd9;
    // ROM data arrives one cycle behind its address, so LOAD writes the previous index
    assign w_ld_we  = (r_state == S_LOAD && r_idx != '0) || r_state == S_LOAD_LAST;
    assign w_ld_val = (rom_data != '0 && rom_data <= 4'd9) ? rom_data : '0;
    assign w_cl_we  = r_state == S_CLEAR && r_blank[r_idx];
    assign w_wr_we  = w_grant && !w_reject;
    assign w_we     = w_ld_we | w_cl_we | w_wr_we;
    assign w_widx   = w_ld_we ? (r_state == S_LOAD_LAST ? IDX_W'(CELLS - 1) : r_idx - 1'b1) :
                      w_cl_we ? r_idx : w_cur;
    assign w_wval   = w_ld_we ? w_ld_val : w_cl_we ? '0 : w_num;
    assign w_old    = r_board[w_widx*CELL_W +: CELL_W];
    assign w_cnt_nx = r_cnt + ((w_old == '0 && w_wval != '0) ? 7'd1 : 7'd0)
                            - ((w_old != '0 && w_wval == '0) ? 7'd1 : 7'd0);

    assign w_row_nx = (mv_up & ~mv_down) ? (r_row == 4'd0 ? 4'd8 : r_row - 4'd1) :
                      (mv_down & ~mv_up) ? (r_row == 4'd8 ? 4'd0 : r_row + 4'd1) : r_row;
    assign w_col_nx = (mv_left & ~mv_right) ? (r_col == 4'd0 ? 4'd8 : r_col - 4'd1) :
                      (mv_right & ~mv_left) ? (r_col == 4'd8 ? 4'd0 : r_col + 4'd1) : r_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_board     <= '0;
            r_blank     <= '1;
            r_row       <= '0;
            r_col       <= '0;
            r_cnt       <= '0;
            r_rom_en    <= 1'b0;
            r_rom_addr  <= '0;
            r_wr_reject <= 1'b0;
        end else begin
            if (w_we) begin
                r_board[w_widx*CELL_W +: CELL_W] <= w_wval;
                r_cnt <= w_cnt_nx;
            end
            if (w_ld_we) r_blank[w_widx] <= (w_ld_val == '0);
            r_wr_reject <= w_grant & w_reject;
            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        r_state    <= S_LOAD;
                        r_idx      <= '0;
                        r_rom_en   <= 1'b1;
                        r_rom_addr <= w_base;
                        r_row      <= '0;
                        r_col      <= '0;
                    end else begin
                        if (clear_start) begin
                            r_state <= S_CLEAR;
                            r_idx   <= '0;
                        end
                        r_row <= w_row_nx;
                        r_col <= w_col_nx;
                    end
                end
                S_LOAD: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IDX_W'(CELLS - 1)) begin
                        r_state    <= S_LOAD_LAST;
                        r_rom_en   <= 1'b0;
                        r_rom_addr <= '0;
                    end else begin
                        r_rom_addr <= r_rom_addr + 1'b1;
                    end
                end
                S_LOAD_LAST: r_state <= S_IDLE;
                S_CLEAR: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IDX_W'(CELLS - 1)) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rom_en      = r_rom_en;
    assign rom_addr    = r_rom_addr;
    assign wr_reject   = r_wr_reject;
    assign board       = r_board;
    assign board_blank = r_blank;
    assign cursor_row  = r_row;
    assign cursor_col  = r_col;
    assign busy        = r_state != S_IDLE;
    assign filled_cnt  = r_cnt;
    assign board_full  = r_cnt == 7'(CELLS);
endmodule

// File: tb/tb_sudoku_board_ctrl.sv
// tb_sudoku_board_ctrl: directed bench with a 1-cycle ROM model, a board model
// and a queue of expected write acknowledges.
module tb_sudoku_board_ctrl;
    logic         clk = 0, rst_n = 0;
    logic         load_start = 0, clear_start = 0;
    logic [1:0]   puzzle_sel = 0;
    logic         rom_en;
    logic [8:0]   rom_addr;
    logic [3:0]   rom_data = 0;
    logic         mv_up = 0, mv_down = 0, mv_left = 0, mv_right = 0;
    logic         kp_req = 0, hw_req = 0;
    logic [3:0]   kp_num = 0, hw_num = 0;
    logic         kp_ack, hw_ack, wr_reject;
    logic [323:0] board;
    logic [80:0]  board_blank;
    logic [3:0]   cursor_row, cursor_col;
    logic         busy, board_full;
    logic [6:0]   filled_cnt;

    logic [3:0]   rom [0:511];
    logic [323:0] exp_board;
    logic [80:0]  exp_blank;
    logic [1:0]   ack_q[$];
    int           addr_q[$];
    int           clues, checks = 0, errors = 0;

    sudoku_board_ctrl dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .puzzle_sel(puzzle_sel),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data), .clear_start(clear_start),
        .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
        .kp_req(kp_req), .kp_num(kp_num), .kp_ack(kp_ack),
        .hw_req(hw_req), .hw_num(hw_num), .hw_ack(hw_ack), .wr_reject(wr_reject),
        .board(board), .board_blank(board_blank), .cursor_row(cursor_row), .cursor_col(cursor_col),
        .busy(busy), .filled_cnt(filled_cnt), .board_full(board_full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [323:0] obs, input logic [323:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_load(input int p);
        clues = 0;
        for (int k = 0; k < 81; k++) begin
            logic [3:0] v;
            v = rom[p*81 + k];
            exp_blank[k] = !(v >= 1 && v <= 9);
            exp_board[k*4 +: 4] = exp_blank[k] ? 4'd0 : v;
            if (!exp_blank[k]) clues++;
        end
    endtask

    task automatic pulse(input logic u, input logic d, input logic l, input logic r);
        mv_up = u; mv_down = d; mv_left = l; mv_right = r;
        step();
        mv_up = 0; mv_down = 0; mv_left = 0; mv_right = 0;
    endtask

    task automatic wait_acks(input int budget);
        for (int n = 0; n < budget && ack_q.size() > 0; n++) begin
            if (kp_ack || hw_ack) begin
                chk("ack", {hw_ack, wr_reject}, ack_q.pop_front());
                if (kp_ack) kp_req = 0;
                if (hw_ack) hw_req = 0;
            end
            if (ack_q.size() > 0) step();
        end
        chk("ack_timeout", ack_q.size(), 0);
        ack_q.delete();
        kp_req = 0;
        hw_req = 0;
        step();
    endtask

    task automatic wr(input logic hw, input logic [3:0] num, input logic rej);
        if (hw) begin hw_req = 1; hw_num = num; end
        else begin kp_req = 1; kp_num = num; end
        ack_q.push_back({hw, rej});
        step();
        wait_acks(20);
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        for (int i = 0; i < 300 && busy; i++) begin
            cycles++;
            if (rom_en) chk("rom_addr", rom_addr, addr_q.size() > 0 ? addr_q.pop_front() : -1);
            step();
        end
    endtask

    initial begin
        int bc;
        logic ack_busy;
        for (int k = 0; k < 81; k++) begin
            rom[k]       = 4'((k % 9) + 1);
            rom[81 + k]  = 4'((k * 5 + 3) % 14);
            rom[162 + k] = 4'(k % 10);
        end
        exp_board = '0;
        exp_blank = '1;
        step(); step();
        chk("rst_board", board, '0);
        chk("rst_blank", board_blank, {81{1'b1}});
        chk("rst_misc", {cursor_row, cursor_col, busy, kp_ack, hw_ack, wr_reject, rom_en, board_full, filled_cnt, rom_addr}, '0);
        rst_n = 1;
        step();

        // puzzle 1 load
        for (int a = 81; a <= 161; a++) addr_q.push_back(a);
        load_start = 1; puzzle_sel = 1;
        step();
        load_start = 0;
        wait_idle(bc);
        chk("load_busy_cycles", bc, 82);
        chk("load_addr_all_issued", addr_q.size(), 0);
        model_load(1);
        chk("load_board", board, exp_board);
        chk("load_blank", board_blank, exp_blank);
        chk("load_cnt", filled_cnt, clues);

        // cursor wrap and cancelling moves
        pulse(1, 0, 0, 0);
        chk("cur_up_wrap", {cursor_row, cursor_col}, {4'd8, 4'd0});
        pulse(0, 0, 1, 0);
        chk("cur_left_wrap", {cursor_row, cursor_col}, {4'd8, 4'd8});
        pulse(1, 1, 0, 1);
        chk("cur_cancel_right", {cursor_row, cursor_col}, {4'd8, 4'd0});

        // simultaneous requests on editable cell 72: kp first, then hw
        kp_req = 1; kp_num = 3; hw_req = 1; hw_num = 7;
        ack_q.push_back(2'b00);
        ack_q.push_back(2'b10);
        step();
        wait_acks(20);
        exp_board[72*4 +: 4] = 7;
        chk("dual_cell72", board[72*4 +: 4], 4'd7);
        chk("dual_cnt", filled_cnt, clues + 1);

        // rejected writes: clue cell 73, then num 12 on cell 72
        pulse(0, 0, 0, 1);
        wr(0, 4'd5, 1);
        chk("clue_unchanged", board, exp_board);
        pulse(0, 0, 1, 0);
        wr(0, 4'd12, 1);
        chk("big_num_unchanged", board, exp_board);
        chk("reject_cnt", filled_cnt, clues + 1);

        // fill cells 80 and 77, then clear with a keypad request held
        pulse(0, 0, 1, 0);
        wr(0, 4'd2, 0);
        exp_board[80*4 +: 4] = 2;
        pulse(0, 0, 1, 0); pulse(0, 0, 1, 0); pulse(0, 0, 1, 0);
        wr(1, 4'd9, 0);
        exp_board[77*4 +: 4] = 9;
        chk("filled_board", board, exp_board);
        chk("filled_cnt3", filled_cnt, clues + 3);
        clear_start = 1;
        step();
        clear_start = 0;
        kp_req = 1; kp_num = 4;
        ack_q.push_back(2'b00);
        bc = 0; ack_busy = 0;
        for (int i = 0; i < 200 && busy; i++) begin
            bc++;
            if (kp_ack) ack_busy = 1;
            step();
        end
        chk("clear_busy_cycles", bc, 81);
        chk("no_ack_while_busy", ack_busy, 0);
        for (int k = 0; k < 81; k++) if (exp_blank[k]) exp_board[k*4 +: 4] = 0;
        chk("clear_board", board, exp_board);
        chk("clear_cnt", filled_cnt, clues);
        wait_acks(10);
        chk("post_clear_write", board[77*4 +: 4], 4'd4);

        // reset during load at index 40
        load_start = 1; puzzle_sel = 2;
        step();
        load_start = 0;
        for (int i = 0; i < 100 && rom_addr != 9'd202; i++) step();
        chk("reach_idx40", rom_addr, 9'd202);
        rst_n = 0;
        step();
        chk("abort_board", board, '0);
        chk("abort_blank", board_blank, {81{1'b1}});
        chk("abort_misc", {busy, rom_en, filled_cnt, rom_addr}, '0);
        rst_n = 1;
        step();

        // out-of-range puzzle maps to puzzle 0, which fills the board
        for (int a = 1; a <= 80; a++) addr_q.push_back(a);
        load_start = 1; puzzle_sel = 3;
        step();
        load_start = 0;
        chk("sel3_base", {rom_en, rom_addr}, {1'b1, 9'd0});
        step();
        wait_idle(bc);
        model_load(0);
        chk("full_board", board, exp_board);
        chk("full_cnt", {board_full, filled_cnt}, {1'b1, 7'd81});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
